fwd_hazard_ctrl: RTL and testbench

- Control-side counterpart of the 4-input operand selectors in front of the ALU.
- Tracks destination-register metadata through its own E/M/W shadow pipeline and produces the 2-bit forwarding selects for ALU operands A and B.
- Detects load-use and taken-branch hazards and drives the stall/flush lines to the datapath pipeline registers.
- Sits beside the 5-stage core datapath: decode feeds it, the operand selectors consume it.

---
 rtl/fwd_hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use/branch hazard control for a 5-stage core.
// Optional stall/flush performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module fwd_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SEL_WIDTH      = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [REG_ADDR_WIDTH-1:0] rs1_d,
    input  logic [REG_ADDR_WIDTH-1:0] rs2_d,
    input  logic [REG_ADDR_WIDTH-1:0] rd_d,
    input  logic                      reg_write_d,
    input  logic                      is_load_d,
    input  logic                      branch_taken_e,
    output logic [SEL_WIDTH-1:0]      fwd_a_sel,
    output logic [SEL_WIDTH-1:0]      fwd_b_sel,
    output logic                      stall_f,
    output logic                      stall_d,
    output logic                      flush_d,
    output logic                      flush_e
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]               stall_cnt,
    output logic [31:0]               flush_cnt
`endif
);

    localparam logic [SEL_WIDTH-1:0]      SEL_RF  = {SEL_WIDTH{1'b0}};
    localparam logic [SEL_WIDTH-1:0]      SEL_WB  = {{(SEL_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [SEL_WIDTH-1:0]      SEL_MEM = {1'b1, {(SEL_WIDTH-1){1'b0}}};
    localparam logic [REG_ADDR_WIDTH-1:0] REG_X0  = {REG_ADDR_WIDTH{1'b0}};

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rs1;
        logic [REG_ADDR_WIDTH-1:0] rs2;
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
        logic                      is_load;
    } ex_meta_t;

    // Past EX only the write-back identity matters for forwarding decisions.
    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic                      reg_write;
    } wr_meta_t;

    localparam ex_meta_t EX_BUBBLE = '{rs1: REG_X0, rs2: REG_X0, rd: REG_X0,
                                       reg_write: 1'b0, is_load: 1'b0};
    localparam wr_meta_t WR_BUBBLE = '{rd: REG_X0, reg_write: 1'b0};

    ex_meta_t e_q, e_d;
    wr_meta_t m_q, m_d;
    wr_meta_t w_q, w_d;
    logic     lu_s;

    function automatic logic [SEL_WIDTH-1:0] fwd_select(
        input wr_meta_t                  m,
        input wr_meta_t                  w,
        input logic [REG_ADDR_WIDTH-1:0] src
    );
        logic [SEL_WIDTH-1:0] sel;
        if (m.reg_write && (m.rd != REG_X0) && (m.rd == src)) begin
            sel = SEL_MEM;
        end else if (w.reg_write && (w.rd != REG_X0) && (w.rd == src)) begin
            sel = SEL_WB;
        end else begin
            sel = SEL_RF;
        end
        return sel;
    endfunction

    // Hazard detection; a taken branch overrides the stall since ID is on the wrong path.
    always_comb begin
        lu_s = e_q.is_load && (e_q.rd != REG_X0) &&
               ((e_q.rd == rs1_d) || (e_q.rd == rs2_d));
        if (rst_n) begin
            stall_f = lu_s && !branch_taken_e;
            stall_d = lu_s && !branch_taken_e;
            flush_d = branch_taken_e;
            flush_e = lu_s || branch_taken_e;
        end else begin
            stall_f = 1'b0;
            stall_d = 1'b0;
            flush_d = 1'b0;
            flush_e = 1'b0;
        end
    end

    // Operand forwarding selects, valid while the consumer sits in EX.
    always_comb begin
        fwd_a_sel = fwd_select(m_q, w_q, e_q.rs1);
        fwd_b_sel = fwd_select(m_q, w_q, e_q.rs2);
    end

    // Shadow pipeline next state.
    always_comb begin
        if (flush_e) begin
            e_d = EX_BUBBLE;
        end else begin
            e_d = '{rs1: rs1_d, rs2: rs2_d, rd: rd_d,
                    reg_write: reg_write_d, is_load: is_load_d};
        end
        m_d = '{rd: e_q.rd, reg_write: e_q.reg_write};
        w_d = m_q;
    end

    // Shadow pipeline registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q <= EX_BUBBLE;
            m_q <= WR_BUBBLE;
            w_q <= WR_BUBBLE;
        end else begin
            e_q <= e_d;
            m_q <= m_d;
            w_q <= w_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;

    // Event counters, free-running with natural wrap.
    always_comb begin
        if (stall_f) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
        if (flush_d) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end else begin
            flush_cnt_d = flush_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus randomized
// traffic against an instruction-history model of the hazard rules.
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs1_d = 5'd0, rs2_d = 5'd0, rd_d = 5'd0;
    logic       reg_write_d = 1'b0, is_load_d = 1'b0, branch_taken_e = 1'b0;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall_f, stall_d, flush_d, flush_e;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    int unsigned m_stall_cnt = 0, m_flush_cnt = 0;
`endif

    fwd_hazard_ctrl #(.REG_ADDR_WIDTH(5), .SEL_WIDTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .reg_write_d(reg_write_d), .is_load_d(is_load_d),
        .branch_taken_e(branch_taken_e),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_f(stall_f), .stall_d(stall_d),
        .flush_d(flush_d), .flush_e(flush_e)
`ifdef HAZARD_PERF_CNT_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int rs1, rs2, rd;
        bit wr, ld;
    } instr_t;

    // hist[0] = instruction in EX, hist[1] one stage older, hist[2] two stages older
    instr_t hist[3];
    int n_cmp = 0, n_err = 0;
    logic [1:0] s_fa, s_fb;
    logic       s_sf, s_sd, s_fd, s_fe;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Newest older instruction writing src decides the select: age 1 -> 2'b10, age 2 -> 2'b01.
    function automatic int model_fwd(input int src);
        for (int age = 1; age <= 2; age++)
            if (hist[age].wr && hist[age].rd != 0 && hist[age].rd == src)
                return (age == 1) ? 2 : 1;
        return 0;
    endfunction

    function automatic bit model_lu();
        return hist[0].ld && hist[0].rd != 0 &&
               (hist[0].rd == int'(rs1_d) || hist[0].rd == int'(rs2_d));
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 3; i++) hist[i] = '{0, 0, 0, 1'b0, 1'b0};
    endtask

    // Sample at negedge, compare against the model, then advance model over the next edge.
    task automatic tick();
        bit lu, br, ex_stall, ex_flush_e;
        int ea, eb;
        @(negedge clk);
        s_fa = fwd_a_sel; s_fb = fwd_b_sel;
        s_sf = stall_f; s_sd = stall_d; s_fd = flush_d; s_fe = flush_e;
        lu = model_lu();
        br = branch_taken_e;
        ea = model_fwd(hist[0].rs1);
        eb = model_fwd(hist[0].rs2);
        if (!rst_n) begin
            lu = 1'b0; br = 1'b0; ea = 0; eb = 0;
        end
        ex_stall = lu && !br;
        ex_flush_e = lu || br;
        cmp("fwd_a_sel", {30'd0, s_fa}, ea);
        cmp("fwd_b_sel", {30'd0, s_fb}, eb);
        cmp("stall_f", {31'd0, s_sf}, {31'd0, ex_stall});
        cmp("stall_d", {31'd0, s_sd}, {31'd0, ex_stall});
        cmp("flush_d", {31'd0, s_fd}, {31'd0, br});
        cmp("flush_e", {31'd0, s_fe}, {31'd0, ex_flush_e});
`ifdef HAZARD_PERF_CNT_EN
        cmp("stall_cnt", stall_cnt, rst_n ? m_stall_cnt : 32'd0);
        cmp("flush_cnt", flush_cnt, rst_n ? m_flush_cnt : 32'd0);
`endif
        if (!rst_n) begin
            clear_model();
`ifdef HAZARD_PERF_CNT_EN
            m_stall_cnt = 0; m_flush_cnt = 0;
`endif
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            if (ex_flush_e) hist[0] = '{0, 0, 0, 1'b0, 1'b0};
            else hist[0] = '{int'(rs1_d), int'(rs2_d), int'(rd_d), reg_write_d, is_load_d};
`ifdef HAZARD_PERF_CNT_EN
            if (ex_stall) m_stall_cnt++;
            if (br) m_flush_cnt++;
`endif
        end
        @(posedge clk);
        #1;
    endtask

    task automatic id(input int r1, input int r2, input int rd, input bit wr, input bit ld, input bit br);
        rs1_d = r1[4:0]; rs2_d = r2[4:0]; rd_d = rd[4:0];
        reg_write_d = wr; is_load_d = ld; branch_taken_e = br;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            id(0, 0, 0, 1'b0, 1'b0, 1'b0);
            tick();
        end
    endtask

    initial begin
        clear_model();
        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            id($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
               1'($urandom), 1'($urandom), 1'($urandom));
            tick();
            cmp("rst_sel", {28'd0, s_fa, s_fb}, 32'd0);
            cmp("rst_ctl", {28'd0, s_sf, s_sd, s_fd, s_fe}, 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);
        cmp("idle_ctl", {26'd0, s_fa, s_fb, s_sf, s_sd}, 32'd0);

        // EX/MEM forward.
        id(0, 0, 5, 1'b1, 1'b0, 1'b0); tick();
        id(5, 0, 0, 1'b0, 1'b0, 1'b0); tick();
        idle(1);
        cmp("exmem_a", {30'd0, s_fa}, 32'd2);
        cmp("exmem_b", {30'd0, s_fb}, 32'd0);

        // WB forward.
        id(0, 0, 7, 1'b1, 1'b0, 1'b0); tick();
        id(1, 2, 9, 1'b1, 1'b0, 1'b0); tick();
        id(0, 7, 0, 1'b0, 1'b0, 1'b0); tick();
        idle(1);
        cmp("wb_b", {30'd0, s_fb}, 32'd1);

        // MEM beats WB.
        id(0, 0, 7, 1'b1, 1'b0, 1'b0); tick();
        id(0, 0, 7, 1'b1, 1'b0, 1'b0); tick();
        id(0, 7, 0, 1'b0, 1'b0, 1'b0); tick();
        idle(1);
        cmp("prio_b", {30'd0, s_fb}, 32'd2);

        // Load-use: one bubble, then WB forward.
        idle(2);
        id(0, 0, 3, 1'b1, 1'b1, 1'b0); tick();
        id(3, 0, 0, 1'b0, 1'b0, 1'b0); tick();
        cmp("lu_stall", {29'd0, s_sf, s_sd, s_fe}, 32'd7);
        tick();
        cmp("lu_release", {29'd0, s_sf, s_sd, s_fe}, 32'd0);
        idle(1);
        cmp("lu_fwd_a", {30'd0, s_fa}, 32'd1);

        // Branch and load-use together: branch wins.
        id(0, 0, 4, 1'b1, 1'b1, 1'b0); tick();
        id(0, 4, 0, 1'b0, 1'b0, 1'b1); tick();
        cmp("br_lu", {28'd0, s_sf, s_sd, s_fd, s_fe}, 32'd3);

        // x0 never forwards or stalls.
        idle(2);
        id(0, 0, 0, 1'b1, 1'b1, 1'b0); tick();
        id(0, 0, 0, 1'b0, 1'b0, 1'b0); tick();
        cmp("x0_nostall", {31'd0, s_sf}, 32'd0);
        idle(1);
        cmp("x0_sel", {28'd0, s_fa, s_fb}, 32'd0);

        // Async reset mid-run drops pending hazard and flush at once.
        id(0, 0, 6, 1'b1, 1'b1, 1'b0); tick();
        id(6, 0, 0, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        #1;
        cmp("midrst_ctl", {28'd0, stall_f, stall_d, flush_d, flush_e}, 32'd0);
        branch_taken_e = 1'b0;
        tick();
        rst_n = 1'b1;
        idle(2);

`ifdef HAZARD_PERF_CNT_EN
        for (int k = 0; k < 3; k++) begin
            id(0, 0, 3, 1'b1, 1'b1, 1'b0); tick();
            id(3, 0, 0, 1'b0, 1'b0, 1'b0); tick();
            tick();
            idle(1);
        end
        for (int k = 0; k < 2; k++) begin
            id(0, 0, 0, 1'b0, 1'b0, 1'b1); tick();
            idle(1);
        end
        cmp("stall_cnt_lit", stall_cnt, 32'd3);
        cmp("flush_cnt_lit", flush_cnt, 32'd2);
        rst_n = 1'b0;
        #1;
        cmp("stall_cnt_rst", stall_cnt, 32'd0);
        cmp("flush_cnt_rst", flush_cnt, 32'd0);
        tick();
        rst_n = 1'b1;
        idle(1);
`endif

        // Randomized traffic on a small register set to provoke hazards.
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 249) == 0) ? 1'b0 : 1'b1;
            id($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom), ($urandom_range(0, 2) == 0), ($urandom_range(0, 7) == 0));
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
